// File: rtl/inst_fetch_queue_pkg.sv
// ============================================================================
// inst_fetch_queue_pkg: entry type shared by fetch, the fetch queue and decode.
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_fetch_queue_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    virt_t   pc;
    uint32_t inst;
    logic    iaddr_adel;
    logic    itlb_refill;
    logic    itlb_invalid;
  } fq_entry_t;

  localparam int FQ_ENTRY_WIDTH = $bits(fq_entry_t);

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_lead_ones.sv
// ============================================================================
// fq_lead_ones: counts consecutive ones of a mask starting from bit 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module fq_lead_ones #(
  parameter int N = 2
) (
  input  logic [N-1:0]             bits_i,
  output logic [$clog2(N+1)-1:0]   count_o
);

  localparam int CW = $clog2(N + 1);

  logic run;

  always_comb begin
    count_o = '0;
    run     = 1'b1;
    for (int i = 0; i < N; i++) begin
      run = run & bits_i[i];
      if (run) count_o = count_o + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// inst_fetch_queue: multi-push / multi-pop FWFT queue between fetch and decode.
// Define FQ_BYPASS_EN to forward pushed entries to decode in the same cycle.
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int N_FETCH = 2,
  parameter int N_ISSUE = 2,
  parameter int DEPTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [N_FETCH-1:0]                  push_valid,
  input  logic [N_FETCH*FQ_ENTRY_WIDTH-1:0]   push_data,
  output logic                                push_ready,
  output logic [N_ISSUE-1:0]                  pop_valid,
  output logic [N_ISSUE*FQ_ENTRY_WIDTH-1:0]   pop_data,
  input  logic [$clog2(N_ISSUE+1)-1:0]        pop_count,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                empty,
  output logic                                full
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FCW = $clog2(N_FETCH + 1);
  localparam int W   = FQ_ENTRY_WIDTH;

  fq_entry_t      mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [FCW-1:0] lead_cnt;

  int push_cnt;
  int pop_cnt;
  int avail;
  int skip;

  fq_lead_ones #(.N(N_FETCH)) u_lead_ones (
    .bits_i  (push_valid),
    .count_o (lead_cnt)
  );

  // Readiness looks only at the registered occupancy; a same-cycle pop is not credited.
  assign push_ready = (DEPTH - int'(count_q)) >= N_FETCH;

  always_comb begin
    push_cnt = push_ready ? int'(lead_cnt) : 0;
    avail    = int'(count_q);
`ifdef FQ_BYPASS_EN
    if (!flush) avail = avail + push_cnt;
`endif
    pop_cnt = int'(pop_count);
    if (pop_cnt > N_ISSUE) pop_cnt = N_ISSUE;
    if (pop_cnt > avail)   pop_cnt = avail;
    // Pushed slots consumed straight from the bypass path never land in storage.
    skip = (pop_cnt > int'(count_q)) ? pop_cnt - int'(count_q) : 0;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_cnt);
      tail_d  = tail_q + PW'(push_cnt);
      count_d = CW'(int'(count_q) + push_cnt - pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < N_FETCH; k++) begin
        if (k < push_cnt && k >= skip)
          mem_q[tail_q + PW'(k)] <= push_data[k*W +: W];
      end
    end
  end

  always_comb begin
    pop_valid = '0;
    for (int i = 0; i < N_ISSUE; i++) begin
      pop_data[i*W +: W] = mem_q[head_q + PW'(i)];
      if (i < int'(count_q)) begin
        pop_valid[i] = 1'b1;
      end
`ifdef FQ_BYPASS_EN
      else if (!flush) begin
        for (int k = 0; k < N_FETCH; k++) begin
          if (i == int'(count_q) + k && k < push_cnt) begin
            pop_valid[i]       = 1'b1;
            pop_data[i*W +: W] = push_data[k*W +: W];
          end
        end
      end
`endif
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (int'(pop_count) <= avail);
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench: a queue-of-entries reference model predicts each cycle's outputs.
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int N_FETCH = 2;
  localparam int N_ISSUE = 2;
  localparam int DEPTH   = 8;
  localparam int W       = FQ_ENTRY_WIDTH;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic [N_FETCH-1:0]         push_valid;
  logic [N_FETCH*W-1:0]       push_data;
  logic                       push_ready;
  logic [N_ISSUE-1:0]         pop_valid;
  logic [N_ISSUE*W-1:0]       pop_data;
  logic [$clog2(N_ISSUE+1)-1:0] pop_count;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       empty;
  logic                       full;

  always #5 clk = ~clk;

  inst_fetch_queue #(.N_FETCH(N_FETCH), .N_ISSUE(N_ISSUE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_count  (pop_count),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  typedef struct {
    logic [N_ISSUE-1:0]   valid;
    logic [N_ISSUE*W-1:0] data;
    int                   occ;
    logic                 empty;
    logic                 full;
    logic                 ready;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  fq_entry_t   model[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] next_pc;

  task automatic check_val(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every settled cycle with an outstanding prediction is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_val("push_ready", 128'(push_ready), 128'(mon_e.ready));
      check_val("count", 128'(count), 128'(mon_e.occ));
      check_val("empty", 128'(empty), 128'(mon_e.empty));
      check_val("full", 128'(full), 128'(mon_e.full));
      check_val("pop_valid", 128'(pop_valid), 128'(mon_e.valid));
      for (int i = 0; i < N_ISSUE; i++) begin
        if (mon_e.valid[i])
          check_val($sformatf("pop_data[%0d]", i), 128'(pop_data[i*W +: W]), 128'(mon_e.data[i*W +: W]));
      end
    end
  end

  function automatic fq_entry_t mk(input logic [31:0] pc);
    fq_entry_t e;
    e.pc           = pc;
    e.inst         = $urandom;
    e.iaddr_adel   = 1'($urandom_range(0, 1));
    e.itlb_refill  = 1'($urandom_range(0, 1));
    e.itlb_invalid = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic step(input bit fl, input logic [N_FETCH-1:0] mask, input int want_pop);
    exp_t      e;
    fq_entry_t grp [N_FETCH];
    fq_entry_t vis[$];
    int        npush;
    int        npop;
    bit        run;
    bit        rdy;
    @(posedge clk);
    #1;
    rdy   = (DEPTH - model.size()) >= N_FETCH;
    npush = 0;
    run   = 1'b1;
    for (int k = 0; k < N_FETCH; k++) begin
      grp[k] = mk(next_pc + 32'(4 * k));
      run    = run && mask[k];
      if (run) npush++;
    end
    if (!rdy) npush = 0;
    vis = model;
`ifdef FQ_BYPASS_EN
    if (!fl) for (int k = 0; k < npush; k++) vis.push_back(grp[k]);
`endif
    npop = want_pop;
    if (!fl) begin
      if (npop > vis.size()) npop = vis.size();
      if (npop > N_ISSUE)    npop = N_ISSUE;
    end
    e.valid = '0;
    e.data  = '0;
    for (int i = 0; i < N_ISSUE; i++) begin
      if (i < vis.size()) begin
        e.valid[i]       = 1'b1;
        e.data[i*W +: W] = vis[i];
      end
    end
    e.occ   = model.size();
    e.empty = (model.size() == 0);
    e.full  = (model.size() == DEPTH);
    e.ready = rdy;

    rst        = 1'b0;
    flush      = fl;
    push_valid = mask;
    for (int k = 0; k < N_FETCH; k++) push_data[k*W +: W] = grp[k];
    pop_count  = 2'(npop);
    exp_q.push_back(e);

    if (fl) begin
      model.delete();
    end else begin
      for (int k = 0; k < npush; k++) model.push_back(grp[k]);
      for (int k = 0; k < npop; k++) void'(model.pop_front());
      next_pc = next_pc + 32'(4 * npush);
    end
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    flush      = 1'b0;
    push_valid = '0;
    pop_count  = '0;
    model.delete();
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    push_valid = '0;
    push_data  = '0;
    pop_count  = '0;
    next_pc    = 32'hbfc0_0000;
    repeat (2) @(posedge clk);

    // Reset state, then basic push
    step(1'b0, 2'b00, 0);
    step(1'b0, 2'b11, 0);
    step(1'b0, 2'b00, 0);
    // Fill to full, then push held while not ready
    repeat (3) step(1'b0, 2'b11, 0);
    repeat (2) step(1'b0, 2'b11, 0);
    step(1'b0, 2'b00, 0);
    // Wrap-around with steady occupancy of 3
    step(1'b1, 2'b00, 0);
    step(1'b0, 2'b11, 0);
    step(1'b0, 2'b01, 0);
    repeat (12) step(1'b0, 2'b11, 2);
    // Partial masks
    step(1'b1, 2'b00, 0);
    step(1'b0, 2'b01, 0);
    step(1'b0, 2'b10, 0);
    step(1'b0, 2'b00, 1);
    step(1'b0, 2'b00, 0);
    // Flush priority over push and pop
    step(1'b0, 2'b11, 0);
    step(1'b0, 2'b11, 0);
    step(1'b0, 2'b01, 0);
    step(1'b1, 2'b11, 2);
    next_pc = 32'h8000_0180;
    step(1'b0, 2'b01, 0);
    step(1'b0, 2'b00, 0);
    // Drained queue, push and pop together
    step(1'b1, 2'b00, 0);
    step(1'b0, 2'b11, 2);
    step(1'b0, 2'b00, 0);
    // Mid-operation reset
    step(1'b0, 2'b11, 0);
    reset_cycle();
    step(1'b0, 2'b00, 0);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0)
        reset_cycle();
      else
        step($urandom_range(0, 15) == 0, 2'($urandom), int'($urandom_range(0, N_ISSUE)));
    end

    step(1'b0, 2'b00, 0);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
